// File: rtl/fft_result_unloader.sv
// Captures one fftip output frame by xk_index and replays it in natural bin order on a valid/ready stream.
// Optional capture watchdog is compiled in with `define FFT_UNLOADER_TIMEOUT_EN.
module fft_result_unloader #(
    parameter int N_POINTS = 128,
    parameter int IDX_W    = 7,
    parameter int XK_W     = 24,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fft_done,
    input  logic               fft_dv,
    input  logic [IDX_W-1:0]   fft_xk_index,
    input  logic [XK_W-1:0]    fft_xk_re,
    input  logic [XK_W-1:0]    fft_xk_im,
    output logic               fft_unload,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*XK_W-1:0]  m_data,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic               busy,
    output logic               frame_err,
    input  logic               err_clr
);
    typedef enum logic [1:0] {IDLE, UNLOAD, CAPTURE, DRAIN} state_t;

    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_POINTS - 1);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_POINTS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                unload_q, unload_d;
    logic                m_valid_q, m_valid_d;
    logic [2*XK_W-1:0]   m_data_q, m_data_d;
    logic [IDX_W-1:0]    m_index_q, m_index_d;
    logic                m_last_q, m_last_d;
    logic                frame_err_q, frame_err_d;
    logic                wr_en;
    logic                load;
    logic                fire;
    logic                err_set;
    logic                timeout_hit;

    logic [2*XK_W-1:0]   mem [0:N_POINTS-1];

    assign wr_en = (state_q == CAPTURE) && fft_dv;
    assign fire  = m_valid_q && m_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fft_xk_index] <= {fft_xk_im, fft_xk_re};
        end
    end

`ifdef FFT_UNLOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;

    // Restarts on every dv beat; UNLOAD leaves it at zero so the first beat is also bounded.
    always_comb begin
        wdog_d = '0;
        if (state_q == CAPTURE && !fft_dv) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == CAPTURE) && !fft_dv && (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fft_done) begin
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                cnt_d   = '0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (timeout_hit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (fft_dv) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The output register doubles as the RAM read register, so a read is issued
                // whenever the current beat leaves (or none is held).
                load = (cnt_q != N_CNT) && (!m_valid_q || fire);
                if (fire && m_last_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = mem[cnt_q[IDX_W-1:0]];
            m_index_d = cnt_q[IDX_W-1:0];
            m_last_d  = (cnt_q == LAST_CNT);
            cnt_d     = cnt_q + 1'b1;
        end else if (fire) begin
            m_valid_d = 1'b0;
        end

        unload_d = (state_d == UNLOAD);
    end

    assign err_set = (fft_dv && (state_q != CAPTURE)) || timeout_hit;

    always_comb begin
        frame_err_d = frame_err_q;
        if (err_set) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            unload_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_index_q   <= '0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            unload_q    <= unload_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_index_q   <= m_index_d;
            m_last_q    <= m_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign fft_unload = unload_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_index    = m_index_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Directed bench for fft_result_unloader: natural, bit-reversed and back-pressured frames,
// spurious done/dv events, reset mid-drain, and the capture watchdog when compiled in.
module tb_fft_result_unloader;
    localparam int N     = 128;
    localparam int IDX_W = 7;
    localparam int XK_W  = 24;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fft_done;
    logic               fft_dv;
    logic [IDX_W-1:0]   fft_xk_index;
    logic [XK_W-1:0]    fft_xk_re;
    logic [XK_W-1:0]    fft_xk_im;
    logic               fft_unload;
    logic               m_valid;
    logic               m_ready;
    logic [2*XK_W-1:0]  m_data;
    logic [IDX_W-1:0]   m_index;
    logic               m_last;
    logic               busy;
    logic               frame_err;
    logic               err_clr;

    int n_checks = 0;
    int n_pass   = 0;
    int unload_cnt = 0;
    int valid_cnt  = 0;

    fft_result_unloader #(
        .N_POINTS (N),
        .IDX_W    (IDX_W),
        .XK_W     (XK_W),
        .TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fft_done     (fft_done),
        .fft_dv       (fft_dv),
        .fft_xk_index (fft_xk_index),
        .fft_xk_re    (fft_xk_re),
        .fft_xk_im    (fft_xk_im),
        .fft_unload   (fft_unload),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_index      (m_index),
        .m_last       (m_last),
        .busy         (busy),
        .frame_err    (frame_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_unload) unload_cnt++;
        if (m_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*XK_W-1:0] exp_word(input int k);
        logic [XK_W-1:0] re;
        logic [XK_W-1:0] im;
        re = XK_W'(k);
        im = XK_W'(-k);
        return {im, re};
    endfunction

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < IDX_W; b++) begin
            if (((k >> b) & 1) == 1) r = r | (1 << (IDX_W - 1 - b));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("unload_pulse", fft_unload, 1);
        check("busy_rise", busy, 1);
        tick();
        check("unload_single", fft_unload, 0);
    endtask

    // mode 1: bit-reversed order with dv gaps; mode 3: fft_done pulses during capture
    task automatic capture_frame(input int mode, input int n_beats);
        for (int p = 0; p < n_beats; p++) begin
            int idx;
            idx = (mode == 1) ? bitrev(p) : p;
            if (mode == 1 && (p % 10) == 9) begin
                fft_dv = 1'b0;
                tick();
            end
            fft_dv       = 1'b1;
            fft_xk_index = IDX_W'(idx);
            fft_xk_re    = XK_W'(idx);
            fft_xk_im    = XK_W'(-idx);
            fft_done     = (mode == 3) && (p == 10 || p == 11);
            tick();
        end
        fft_dv   = 1'b0;
        fft_done = 1'b0;
    endtask

    // mode 2: back-pressure pattern; mode 3: fft_done pulse during drain
    task automatic drain_frame(input int mode, input int stop_at);
        int got = 0;
        int cyc = 0;
        int hold_left = 5;
        int first_v = -1;
        logic held_v = 1'b0;
        logic [2*XK_W-1:0] held_data = '0;
        logic [IDX_W-1:0] held_idx = '0;
        while (got < stop_at && cyc < 2000) begin
            if (mode == 2) begin
                if (got == 64 && hold_left > 0) begin
                    m_ready = 1'b0;
                    hold_left--;
                end else begin
                    m_ready = ((cyc % 2) == 1);
                end
            end else begin
                m_ready = 1'b1;
            end
            fft_done = (mode == 3) && (cyc == 3);
            @(negedge clk);
            if (m_valid && first_v < 0) first_v = cyc;
            if (held_v) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held_data);
                check("stall_index", m_index, held_idx);
            end
            if (m_valid && m_ready) begin
                check("beat_index", m_index, got);
                check("beat_data", m_data, exp_word(got));
                check("beat_last", m_last, (got == N - 1));
                got++;
                held_v = 1'b0;
            end else if (m_valid) begin
                held_v    = 1'b1;
                held_data = m_data;
                held_idx  = m_index;
            end
            tick();
            cyc++;
        end
        fft_done = 1'b0;
        check("first_valid_cycle", first_v, 1);
        check("beats_delivered", got, stop_at);
    endtask

    task automatic run_frame(input int mode);
        int u0;
        u0 = unload_cnt;
        start_frame();
        capture_frame(mode, N);
        check("valid_before_read", m_valid, 0);
        check("busy_in_drain", busy, 1);
        drain_frame(mode, N);
        check("valid_after_last", m_valid, 0);
        check("busy_after_last", busy, 0);
        check("unload_count", unload_cnt - u0, 1);
        $display("frame mode %0d: %0d beats drained, frame_err=%0d", mode, N, frame_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_unload"}, fft_unload, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_index"}, m_index, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        fft_done     = 1'b0;
        fft_dv       = 1'b0;
        fft_xk_index = '0;
        fft_xk_re    = '0;
        fft_xk_im    = '0;
        m_ready      = 1'b1;
        err_clr      = 1'b0;
        #1;
        check_reset_values("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_frame(0);
        run_frame(1);
        run_frame(2);

        run_frame(3);
        check("err_after_spurious_done", frame_err, 0);
        fft_dv = 1'b1;
        tick();
        fft_dv = 1'b0;
        check("err_stray_dv", frame_err, 1);
        check("busy_stray_dv", busy, 0);
        tick();
        tick();
        tick();
        check("err_sticky", frame_err, 1);
        fft_dv  = 1'b1;
        err_clr = 1'b1;
        tick();
        fft_dv = 1'b0;
        check("err_set_wins", frame_err, 1);
        tick();
        err_clr = 1'b0;
        check("err_cleared", frame_err, 0);
        $display("spurious events: unload pulses total %0d", unload_cnt);

        start_frame();
        capture_frame(0, N);
        drain_frame(0, 40);
        check("pre_reset_index", m_index, 40);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_drain_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);
        $display("reset mid-drain at index 40");
        run_frame(0);

`ifdef FFT_UNLOADER_TIMEOUT_EN
        begin
            int n;
            n = 0;
            start_frame();
            capture_frame(0, 50);
            valid_cnt = 0;
            check("timeout_err_low", frame_err, 0);
            for (n = 1; n <= 100; n++) begin
                tick();
                if (frame_err) break;
            end
            check("timeout_cycles", n, 16);
            check("timeout_idle", busy, 0);
            tick();
            tick();
            check("timeout_no_valid", valid_cnt, 0);
            $display("timeout frame: frame_err after %0d idle cycles", n);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_result_unloader.md
# fft_result_unloader

Consumer-side companion to the `fftip` core.
- Waits for a transform to finish, then pulses `fft_unload` and captures the 128 complex results the core emits with `dv`.
- Stores each result at its `xk_index`, so output order from the core does not matter.
- Replays the frame in natural order (bin 0..N-1) on a valid/ready stream toward the processor-side DMA/FIFO.

## Interface
Parameters:
- `N_POINTS`, 128, transform length (power of two)
- `IDX_W`, 7, log2(N_POINTS); width of `fft_xk_index`
- `XK_W`, 24, width of each of `fft_xk_re` / `fft_xk_im`
- `TIMEOUT`, 1024, max cycles between consecutive `dv` beats in CAPTURE (used only with the macro)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, shared with `fftip`
- `rst_n`  in  1  asynchronous active-low reset
- `fft_done`  in  1  core transform-complete pulse
- `fft_dv`  in  1  core output-data-valid
- `fft_xk_index`  in  IDX_W  bin index of the current output beat
- `fft_xk_re`  in  XK_W  real part, two's complement
- `fft_xk_im`  in  XK_W  imaginary part, two's complement
- `fft_unload`  out  1  one-cycle unload request to the core
- `m_valid`  out  1  stream beat valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  2*XK_W  packed beat: {im, re}, with re in the LSBs
- `m_index`  out  IDX_W  bin index of the current beat
- `m_last`  out  1  high on the beat with `m_index == N_POINTS-1`
- `busy`  out  1  high in any state other than IDLE
- `frame_err`  out  1  sticky error flag
- `err_clr`  in  1  synchronous clear for `frame_err`

## Operation
The block is a four-state FSM: IDLE -> UNLOAD -> CAPTURE -> DRAIN -> IDLE.

- **IDLE**
  - Waits for `fft_done == 1`, then goes to UNLOAD.
- **UNLOAD**
  - Drives `fft_unload` high for exactly one cycle.
  - Clears the capture counter and goes to CAPTURE.
- **CAPTURE**
  - Every cycle with `fft_dv` high writes {im, re} into an N_POINTS x 2*XK_W buffer at address `fft_xk_index` and increments the counter.
  - When the counter reaches N_POINTS (the N-th beat), goes to DRAIN.
  - The buffer is single-port RAM with a one-cycle registered read.
- **DRAIN**
  - Reads the buffer at addresses 0..N-1 and presents each word on the `m_*` stream.
  - A beat transfers when `m_valid && m_ready`.
  - After the transfer with `m_last` high, returns to IDLE.

Rules and boundary conditions:
- `fft_done` in any state other than IDLE: ignored; no second unload is issued.
- `fft_dv` outside CAPTURE: data is discarded and `frame_err` is set.
- Duplicate `fft_xk_index` within a frame: the later write wins. No error is raised; the counter still counts beats, not distinct indices.
- `frame_err` is sticky:
  - It is cleared only by `err_clr` or reset.
  - If `err_clr` and a new error occur in the same cycle, set wins.
- Stream stability: while `m_valid && !m_ready`, `m_data`, `m_index` and `m_last` hold steady. `m_valid` never drops without a transfer.
- Reset mid-operation:
  - All state returns to IDLE immediately and the counter clears.
  - Buffer contents are not cleared; they are don't-care.
  - The core is not notified, so any in-flight `dv` beats after reset set `frame_err`.
- Reset values:
  - `fft_unload` = 0, `m_valid` = 0, `m_data` = 0, `m_index` = 0, `m_last` = 0
  - `busy` = 0, `frame_err` = 0, FSM = IDLE

## Timing
- `fft_done` sampled high at edge t: `fft_unload` is high in cycle t+1 only, and `busy` rises at t+1.
- CAPTURE accepts one beat per cycle with no back-pressure on the core side; `fft_dv` gaps are allowed.
- The N-th `dv` beat captured at edge c: DRAIN starts at c+1, and the first `m_valid` goes high at c+2 (RAM read latency).
- DRAIN throughput is one beat per cycle while `m_ready` is held high. A read-ahead register hides the RAM latency.
- The `m_last` transfer at edge d: `m_valid` is low and `busy` is low from d+1.
- `fft_done` can be accepted again in the cycle after returning to IDLE.

## Configuration
Macro: `FFT_UNLOADER_TIMEOUT_EN`.
- **Defined:**
  - A watchdog counts cycles in CAPTURE since the last `dv` beat. UNLOAD entry counts as the first reference point.
  - When the count reaches `TIMEOUT`, `frame_err` is set and the FSM returns to IDLE without draining.
- **Undefined:**
  - The watchdog logic and the `TIMEOUT` parameter have no effect.
  - CAPTURE waits indefinitely for N_POINTS beats.

## Test plan
- **Basic frame:** pulse `fft_done`, then drive 128 `dv` beats with index k, re = k, im = -k, and `m_ready` tied high.
  - One `fft_unload` pulse.
  - 128 beats out with `m_index` 0..127, `m_data` = {-k, k}.
  - `m_last` high only at index 127; `busy` falls the cycle after.
- **Bit-reversed input order:** feed indices in 7-bit bit-reversed order, carrying data equal to the natural index.
  - Output is in natural order 0..127 with matching data.
- **Back-pressure:** toggle `m_ready` 0/1 every other cycle and hold it low for 5 cycles at index 64.
  - Data is stable while stalled; no beat is lost or duplicated; all 128 beats are delivered.
- **Spurious events:** `fft_done` pulses during CAPTURE and DRAIN, and one `dv` beat occurs in IDLE.
  - No extra `fft_unload`.
  - `frame_err` = 1 after the stray `dv` and stays 1 until `err_clr`, then reads 0.
- **Reset mid-DRAIN:** assert `rst_n` = 0 at index 40.
  - All outputs are at their reset values within the same cycle (asynchronous).
  - After release, a fresh frame drains correctly from index 0.
- **Timeout (macro defined, TIMEOUT = 16):** stop `dv` after 50 beats.
  - `frame_err` rises 16 cycles after the last beat; the FSM returns to IDLE; `m_valid` is never asserted.
